tt_um_pattern_detect_ctrl: RTL and testbench

Programmable serial pattern-detector controller in the Tiny Tapeout top-level pinout. Holds a configurable pattern (1..8 bits) and a run/idle sequencer. Samples a qualified serial bit stream and pulses a Mealy-style match with overlap or non-overlap semantics. Keeps a saturating match count on the output pins.

---
 rtl/tt_pattern_detect_pkg.sv | 37 +++
 rtl/tt_um_pattern_detect_ctrl_if.sv | 24 ++
 rtl/pattern_match_core.sv | 47 ++++
 rtl/tt_um_pattern_detect_ctrl.sv | 138 +++++++++++++
 tb/tb_tt_um_pattern_detect_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pattern_detect_pkg.sv
// Shared types and pin indices for the serial pattern detector.
// Optional build macro: DIN_SYNC_EN (input synchronizer).
package tt_pattern_detect_pkg;

  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 5;
  localparam int LEN_W   = 4;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  localparam int UI_DIN    = 0;
  localparam int UI_VALID  = 1;
  localparam int UI_CFG_WR = 2;
  localparam int UI_START  = 3;
  localparam int UI_STOP   = 4;
  localparam int UI_OVL    = 5;
  localparam int UI_SEL    = 6;

  localparam int UO_MATCH  = 0;
  localparam int UO_RUN    = 1;
  localparam int UO_SAT    = 2;
  localparam int UO_CNT    = 3;

  // Low len bits set; len is 1..8 so the 9-bit shift never overflows.
  function automatic logic [PAT_MAX-1:0] len_mask(
    input logic [LEN_W-1:0] len
  );
    return PAT_MAX'((9'd1 << len) - 9'd1);
  endfunction

endpackage

// File: rtl/tt_um_pattern_detect_ctrl_if.sv
// Control/compare bundle between the sequencer and the match core.
// Optional build macro: DIN_SYNC_EN (input synchronizer).
interface tt_um_pattern_detect_ctrl_if;
  import tt_pattern_detect_pkg::*;

  logic               shift_en;
  logic               clear;
  logic               din;
  logic               overlap;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               hit;

  modport master (
    output shift_en, clear, din, overlap, pattern, len,
    input  hit
  );

  modport slave (
    input  shift_en, clear, din, overlap, pattern, len,
    output hit
  );

endinterface

// File: rtl/pattern_match_core.sv
// Bit history, fill tracking and masked compare for the detector.
// Optional build macro: DIN_SYNC_EN (input synchronizer).
module pattern_match_core
  import tt_pattern_detect_pkg::*;
(
  input logic clk,
  input logic rst_n,
  tt_um_pattern_detect_ctrl_if.slave m
);

  logic [PAT_MAX-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [PAT_MAX-1:0] w_window;
  logic [LEN_W-1:0]   w_fill_inc;
  logic               w_hit;

  always_comb begin
    w_window   = {r_hist[PAT_MAX-2:0], m.din};
    w_fill_inc = r_fill + 4'd1;
    w_hit      = m.shift_en
               && (w_fill_inc >= m.len)
               && (((w_window ^ m.pattern)
                    & len_mask(m.len)) == '0);
  end

  assign m.hit = w_hit;

  // Non-overlap mode restarts the fill so the next hit needs len new bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (m.clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (m.shift_en) begin
      r_hist <= w_window;
      if (w_hit && !m.overlap)
        r_fill <= '0;
      else if (w_fill_inc > FILL_MAX)
        r_fill <= FILL_MAX;
      else
        r_fill <= w_fill_inc;
    end
  end

endmodule

// File: rtl/tt_um_pattern_detect_ctrl.sv
// Pattern detector top: sequencer, config, match counter, pin map.
// Optional build macro: DIN_SYNC_EN (2-flop sync on ui_in[6:0]).
module tt_um_pattern_detect_ctrl
  import tt_pattern_detect_pkg::*;
#(
  parameter logic [7:0] RST_PATTERN = 8'h07,
  parameter int         RST_LEN     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]         w_ui;
  state_t             r_state;
  state_t             w_next;
  logic [PAT_MAX-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_match;
  logic               w_running;
  logic               w_clear;
  logic               w_shift;
  logic               w_hit;
  logic               w_unused;

  assign w_unused = ui_in[7];

`ifdef DIN_SYNC_EN
  logic [6:0] r_sync1;
  logic [6:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else if (ena) begin
      r_sync1 <= ui_in[6:0];
      r_sync2 <= r_sync1;
    end
  end

  assign w_ui = r_sync2;
`else
  assign w_ui = ui_in[6:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else if (ena)
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_ui[UI_START] && !w_ui[UI_STOP])
              w_next = ARM;
      ARM:  w_next = w_ui[UI_STOP] ? IDLE : RUN;
      RUN:  if (w_ui[UI_STOP])
              w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_running = (r_state != IDLE);
  assign w_clear   = ena && (r_state == ARM);
  // A stop in the sampling cycle discards that bit.
  assign w_shift   = ena && (r_state == RUN)
                   && w_ui[UI_VALID] && !w_ui[UI_STOP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= RST_PATTERN;
      r_len     <= LEN_W'(RST_LEN);
    end else if (ena && r_state == IDLE
                 && w_ui[UI_CFG_WR]) begin
      if (w_ui[UI_SEL])
        r_len <= {1'b0, uio_in[2:0]} + 4'd1;
      else
        r_pattern <= uio_in;
    end
  end

  tt_um_pattern_detect_ctrl_if u_mif ();

  assign u_mif.shift_en = w_shift;
  assign u_mif.clear    = w_clear;
  assign u_mif.din      = w_ui[UI_DIN];
  assign u_mif.overlap  = w_ui[UI_OVL];
  assign u_mif.pattern  = r_pattern;
  assign u_mif.len      = r_len;
  assign w_hit          = u_mif.hit;

  pattern_match_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (u_mif)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else if (ena) begin
      r_match <= w_hit;
      if (w_clear) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_hit && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
        r_sat <= (r_cnt == CNT_MAX - 1'b1);
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[UO_MATCH]             = r_match;
    uo_out[UO_RUN]               = w_running;
    uo_out[UO_SAT]               = r_sat;
    uo_out[UO_CNT +: CNT_W]      = r_cnt;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_pattern_detect_ctrl.sv
// Scoreboard bench for the pattern detector top.
// Build with DIN_SYNC_EN to check the +2 cycle input latency.
module tb_tt_um_pattern_detect_ctrl;

`ifdef DIN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] m;
    logic [7:0] e;
  } exp_t;

  exp_t  q[$];
  string tag = "init";
  int    idx = 0;

  tt_um_pattern_detect_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always begin
    exp_t it;
    @(posedge clk);
    #1;
    if (q.size() > LAT) begin
      it = q.pop_front();
      if (it.m != 8'h00)
        chk(it.name, uo_out & it.m, it.e & it.m);
    end
  end

  function automatic logic [7:0] U(input bit din, input bit v,
    input bit wr, input bit st, input bit sp,
    input bit ov, input bit sel);
    return {1'b0, sel, ov, sp, st, wr, v, din};
  endfunction

  function automatic logic [7:0] E(input bit mt, input bit r,
    input bit s, input int c);
    return {c[4:0], s, r, mt};
  endfunction

  task automatic step(input logic [7:0] ui,
                      input logic [7:0] uio,
                      input logic en,
                      input logic [7:0] e,
                      input logic [7:0] m);
    exp_t it;
    @(negedge clk);
    ui_in  = ui;
    uio_in = uio;
    ena    = en;
    it.name = $sformatf("%s#%0d", tag, idx);
    it.m = m;
    it.e = e;
    q.push_back(it);
    idx++;
  endtask

  task automatic s(input logic [7:0] ui, input logic [7:0] e);
    step(ui, 8'h00, 1'b1, e, 8'hFF);
  endtask

  localparam logic [7:0] NOP = 8'h00;

  initial begin
    logic [6:0] str;
    bit         b;
    str = 7'b1101101;

    #2 rst_n = 1'b0;
    #2;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    tag = "def_ovl1"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,0));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 6; k++)
      s(U(1,1,0,0,0,1,0), E(k >= 3, 1, 0, (k >= 3) ? k - 2 : 0));
    s(U(0,0,0,0,1,0,0), E(0,0,0,4));
    s(NOP, E(0,0,0,4));

    tag = "def_ovl0"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,4));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 6; k++)
      s(U(1,1,0,0,0,0,0),
        E(k == 3 || k == 6, 1, 0, (k >= 6) ? 2 : (k >= 3) ? 1 : 0));
    s(U(0,0,0,0,1,0,0), E(0,0,0,2));

`ifndef DIN_SYNC_EN
    tag = "cfg_ovl1"; idx = 0;
    step(U(0,0,1,0,0,0,0), 8'h0B, 1'b1, E(0,0,0,2), 8'hFF);
    step(U(0,0,1,0,0,0,1), 8'h03, 1'b1, E(0,0,0,2), 8'hFF);
    s(U(0,0,0,1,0,0,0), E(0,1,0,2));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 7; k++) begin
      b = str[k-1];
      s(U(b,1,0,0,0,1,0),
        E(k == 4 || k == 7, 1, 0, (k >= 7) ? 2 : (k >= 4) ? 1 : 0));
    end
    s(U(0,0,0,0,1,0,0), E(0,0,0,2));

    tag = "cfg_ovl0"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,2));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 7; k++) begin
      b = str[k-1];
      s(U(b,1,0,0,0,0,0), E(k == 4, 1, 0, (k >= 4) ? 1 : 0));
    end
    s(U(0,0,0,0,1,0,0), E(0,0,0,1));

    tag = "runcfg_gaps"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,1));
    s(NOP, E(0,1,0,0));
    step(U(0,0,1,0,0,0,0), 8'hFF, 1'b1, E(0,1,0,0), 8'hFF);
    for (int k = 1; k <= 7; k++) begin
      b = str[k-1];
      s(U(b,1,0,0,0,1,0),
        E(k == 4 || k == 7, 1, 0, (k >= 7) ? 2 : (k >= 4) ? 1 : 0));
      s(U(!b,0,0,0,0,1,0),
        E(0, 1, 0, (k >= 7) ? 2 : (k >= 4) ? 1 : 0));
    end
    s(U(0,0,0,0,1,0,0), E(0,0,0,2));

    tag = "stop_hit"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,2));
    s(NOP, E(0,1,0,0));
    s(U(1,1,0,0,0,1,0), E(0,1,0,0));
    s(U(0,1,0,0,0,1,0), E(0,1,0,0));
    s(U(1,1,0,0,0,1,0), E(0,1,0,0));
    s(U(1,1,0,0,1,1,0), E(0,0,0,0));
    s(NOP, E(0,0,0,0));

    tag = "ena_hold"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,0));
    s(NOP, E(0,1,0,0));
    s(U(1,1,0,0,0,1,0), E(0,1,0,0));
    s(U(0,1,0,0,0,1,0), E(0,1,0,0));
    for (int k = 0; k < 3; k++)
      step(U(0,1,0,0,0,1,0), 8'h00, 1'b0, E(0,1,0,0), 8'hFF);
    s(U(1,1,0,0,0,1,0), E(0,1,0,0));
    s(U(1,1,0,0,0,1,0), E(1,1,0,1));
    step(U(1,1,0,0,1,1,0), 8'h00, 1'b0, E(1,1,0,1), 8'hFF);
    s(U(0,0,0,0,1,0,0), E(0,0,0,1));

    tag = "sat"; idx = 0;
    step(U(0,0,1,0,0,0,0), 8'h01, 1'b1, E(0,0,0,1), 8'hFF);
    step(U(0,0,1,0,0,0,1), 8'h00, 1'b1, E(0,0,0,1), 8'hFF);
    s(U(0,0,0,1,0,0,0), E(0,1,0,1));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 40; k++)
      s(U(1,1,0,0,0,0,0), E(1, 1, k >= 31, (k >= 31) ? 31 : k));
    s(U(0,0,0,0,1,0,0), E(0,0,1,31));

    tag = "rst_mid"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,1,31));
    s(NOP, E(0,1,0,0));
    s(U(1,1,0,0,0,1,0), E(1,1,0,1));
    s(U(1,1,0,0,0,1,0), E(1,1,0,2));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid_async", uo_out, 8'h00);
    @(negedge clk);
    ui_in = '0;
    rst_n = 1'b1;

    tag = "post_rst"; idx = 0;
    s(U(0,0,0,1,0,0,0), E(0,1,0,0));
    s(NOP, E(0,1,0,0));
    for (int k = 1; k <= 3; k++)
      s(U(1,1,0,0,0,1,0), E(k == 3, 1, 0, (k == 3) ? 1 : 0));
    s(U(0,0,0,0,1,0,0), E(0,0,0,1));
`endif

    tag = "flush"; idx = 0;
    for (int k = 0; k < LAT; k++)
      step(NOP, 8'h00, 1'b1, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("queue_drained", 8'(q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
